// File: rtl/umem_arbiter_if.sv
// Core-side fetch/data handshakes plus the unified-memory port, bundled for the arbiter.
// master = the arbiter's view; slave = the core + memory environment's view.
interface umem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wd;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_ack;
  logic [31:0] mem_rd;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wd, mem_ack, mem_rd,
    output i_done, i_rdata, i_err, i_stall, d_done, d_rdata, d_err, d_stall,
    output mem_req, mem_we, mem_addr, mem_wd
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wd, mem_ack, mem_rd,
    input  i_done, i_rdata, i_err, i_stall, d_done, d_rdata, d_err, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/umem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and data sides.
// IDLE grants, BUSY waits for mem_ack or timeout, RESP pulses done for one cycle.
module umem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic            clk,
  input logic            reset,
  umem_arbiter_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic       G_I    = 1'b0;
  localparam logic       G_D    = 1'b1;

  logic [1:0]    state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic          gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wd_q, mem_wd_d;
  logic          i_done_q, i_done_d, i_err_q, i_err_d;
  logic          d_done_q, d_done_d, d_err_q, d_err_d;
  logic [31:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          any_req, grant_dside, misaligned;

  assign any_req     = bus.i_req | bus.d_req;
  // On a tie the side that did not win last time goes first.
  assign grant_dside = bus.d_req & (~bus.i_req | (last_gnt_q == G_I));
  assign misaligned  = grant_dside & (bus.d_addr[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    i_done_d   = 1'b0;
    d_done_d   = 1'b0;
    i_err_d    = 1'b0;
    d_err_d    = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d      = grant_dside ? G_D : G_I;
          last_gnt_d = grant_dside ? G_D : G_I;
          cnt_d      = '0;
          mem_addr_d = grant_dside ? bus.d_addr : bus.i_addr;
          mem_wd_d   = grant_dside ? bus.d_wd : 32'h0;
          if (misaligned) begin
            state_d   = S_RESP;
            d_done_d  = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = 32'h0;
          end else begin
            state_d   = S_BUSY;
            mem_req_d = 1'b1;
            mem_we_d  = grant_dside & bus.d_we;
          end
        end
      end
      S_BUSY: begin
        if (bus.mem_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (gnt_q == G_D) begin
            d_done_d  = 1'b1;
            d_err_d   = ~bus.mem_ack;
            d_rdata_d = (bus.mem_ack && !mem_we_q) ? bus.mem_rd : 32'h0;
          end else begin
            i_done_d  = 1'b1;
            i_err_d   = ~bus.mem_ack;
            i_rdata_d = bus.mem_ack ? bus.mem_rd : 32'h0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      last_gnt_q <= G_I;
      gnt_q      <= G_I;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'h0;
      mem_wd_q   <= 32'h0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      i_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      i_rdata_q  <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      i_done_q   <= i_done_d;
      d_done_q   <= d_done_d;
      i_err_q    <= i_err_d;
      d_err_q    <= d_err_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wd   = mem_wd_q;
  assign bus.i_done   = i_done_q;
  assign bus.i_err    = i_err_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_done   = d_done_q;
  assign bus.d_err    = d_err_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.i_stall  = bus.i_req & ~i_done_q;
  assign bus.d_stall  = bus.d_req & ~d_done_q;
endmodule
